// File: rtl/lut_loader.sv
// Programmable label->next_pc branch-target table: sweep-clear, streamed load, then lock.
// Latency: one cycle from write handshake to visible entry; read port is combinational.
// Backpressure: wr_ready is low during the clear sweep and once locked. Optional parity: LUT_LOADER_PARITY_EN.
module lut_loader #(
  parameter int LABEL_W = 8,
  parameter int PC_W    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [LABEL_W-1:0] wr_label,
  input  logic [PC_W-1:0]    wr_target,
  input  logic               lock,
  input  logic [LABEL_W-1:0] label,
  output logic [PC_W-1:0]    next_pc,
  output logic               hit,
  output logic               busy,
  output logic               load_done,
  output logic [LABEL_W:0]   count,
  output logic               parity_err
);

  localparam int DEPTH = 2 ** LABEL_W;
  localparam logic [LABEL_W:0] COUNT_MAX = {1'b1, {LABEL_W{1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR,
    S_LOAD,
    S_LOCKED
  } state_t;

  state_t               state_q;
  logic [LABEL_W-1:0]   idx_q;
  logic [LABEL_W:0]     count_q;
  logic [LABEL_W:0]     count_d;
  logic                 wr_ready_q;
  logic                 busy_q;
  logic                 load_done_q;

  // Table storage: no reset, the clear sweep initialises every entry
  logic [DEPTH-1:0]     vld_q;
  logic [PC_W-1:0]      tgt_q [DEPTH];
`ifdef LUT_LOADER_PARITY_EN
  logic [DEPTH-1:0]     par_q;
`endif

  logic                 clr_en;
  logic                 wr_fire;
  logic                 rd_vld;
  logic [PC_W-1:0]      rd_tgt;

  // wr_ready_q is only ever high in LOAD, so the handshake alone qualifies a write
  assign clr_en  = (state_q == S_CLEAR) && !reset;
  assign wr_fire = wr_valid && wr_ready_q && !reset;

  // New-entry counting: overwrites of a valid entry leave the count alone
  always_comb begin
    count_d = count_q;
    if (wr_fire && !vld_q[wr_label] && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Control FSM: CLEAR sweep -> LOAD -> LOCKED, with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      idx_q       <= '0;
      count_q     <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == {LABEL_W{1'b1}}) begin
            state_q    <= S_LOAD;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          // A write in the same cycle as lock still lands
          count_q <= count_d;
          if (lock) begin
            state_q     <= S_LOCKED;
            wr_ready_q  <= 1'b0;
            load_done_q <= 1'b1;
          end
        end
        S_LOCKED: begin
          state_q <= S_LOCKED;
        end
        default: begin
          state_q    <= S_CLEAR;
          idx_q      <= '0;
          wr_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  // Table write port: one cleared entry per sweep cycle, or one loaded entry per handshake
  always_ff @(posedge clk) begin
    if (clr_en) begin
      vld_q[idx_q] <= 1'b0;
      tgt_q[idx_q] <= '0;
`ifdef LUT_LOADER_PARITY_EN
      par_q[idx_q] <= 1'b0;
`endif
    end else if (wr_fire) begin
      vld_q[wr_label] <= 1'b1;
      tgt_q[wr_label] <= wr_target;
`ifdef LUT_LOADER_PARITY_EN
      // Even parity: XOR over {valid, target, parity} is zero for a good entry
      par_q[wr_label] <= ^{1'b1, wr_target};
`endif
    end
  end

  // Combinational lookup; everything reads as empty while the sweep runs
  assign rd_vld  = vld_q[label];
  assign rd_tgt  = tgt_q[label];
  assign next_pc = (!busy_q && rd_vld) ? rd_tgt : '0;
  assign hit     = !busy_q && rd_vld;

`ifdef LUT_LOADER_PARITY_EN
  assign parity_err = !busy_q && (^{rd_vld, rd_tgt, par_q[label]});
`else
  assign parity_err = 1'b0;
`endif

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign count     = count_q;

endmodule
